// File: rtl/ioc_spi_bridge_if.sv
// IOC register-bus bundle between the SPI bridge (master) and the control modules (slave).
interface ioc_spi_bridge_if;
    logic [4:0] o_ioc;
    logic [7:0] o_data_out;
    logic [3:0] o_cs;
    logic       o_fetch_cmd;
    logic       o_load_cmd;
    logic [7:0] i_rd_data_0;
    logic [7:0] i_rd_data_1;
    logic [7:0] i_rd_data_2;
    logic [7:0] i_rd_data_3;

    modport master (
        output o_ioc, o_data_out, o_cs, o_fetch_cmd, o_load_cmd,
        input  i_rd_data_0, i_rd_data_1, i_rd_data_2, i_rd_data_3
    );

    modport slave (
        input  o_ioc, o_data_out, o_cs, o_fetch_cmd, o_load_cmd,
        output i_rd_data_0, i_rd_data_1, i_rd_data_2, i_rd_data_3
    );
endinterface

// File: rtl/ioc_spi_bridge.sv
// SPI mode-0 slave that decodes 16-bit frames into IOC register-bus fetch/load cycles
// and returns the selected module's read data on MISO.
module ioc_spi_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_WAIT     = 2
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_b,
    input  logic              i_spi_sck,
    input  logic              i_spi_mosi,
    input  logic              i_spi_cs_n,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    ioc_spi_bridge_if.master  bus
);

    localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE, CMD, FETCH, WAIT_RD, DATA, LOAD, DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   cs_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [4:0]             bit_cnt;
    logic [6:0]             rx;
    logic [6:0]             tx;
    logic [1:0]             sel;
    logic                   is_write;
    logic [WW-1:0]          wait_cnt;
    logic [7:0]             rd_mux;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd0: rd_mux = bus.i_rd_data_0;
            2'd1: rd_mux = bus.i_rd_data_1;
            2'd2: rd_mux = bus.i_rd_data_2;
            2'd3: rd_mux = bus.i_rd_data_3;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sck_sync        <= '0;
            mosi_sync       <= '0;
            cs_sync         <= '1;
            sck_d           <= 1'b0;
            cs_d            <= 1'b1;
            state           <= IDLE;
            bit_cnt         <= '0;
            rx              <= '0;
            tx              <= '0;
            sel             <= '0;
            is_write        <= 1'b0;
            wait_cnt        <= '0;
            o_spi_miso      <= 1'b0;
            o_spi_miso_oe   <= 1'b0;
            bus.o_ioc       <= '0;
            bus.o_data_out  <= '0;
            bus.o_cs        <= '0;
            bus.o_fetch_cmd <= 1'b0;
            bus.o_load_cmd  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            o_spi_miso_oe <= ~cs_s;

            bus.o_cs        <= '0;
            bus.o_fetch_cmd <= 1'b0;
            bus.o_load_cmd  <= 1'b0;

            // CS_n rising outranks any SCK edge detected in the same cycle.
            if (cs_rise) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                o_spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt    <= '0;
                        o_spi_miso <= 1'b0;
                        if (cs_fall) state <= CMD;
                    end
                    CMD: begin
                        if (sck_rise) begin
                            rx      <= {rx[5:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bus.o_ioc <= {rx[3:0], mosi_s};
                                sel       <= rx[5:4];
                                is_write  <= rx[6];
                                if (rx[6]) begin
                                    state <= DATA;
                                end else begin
                                    // Strobe registered on entry so it coincides with FETCH.
                                    bus.o_cs        <= onehot(rx[5:4]);
                                    bus.o_fetch_cmd <= 1'b1;
                                    state           <= FETCH;
                                end
                            end
                        end
                    end
                    FETCH: begin
                        wait_cnt <= '0;
                        state    <= WAIT_RD;
                    end
                    WAIT_RD: begin
                        if (wait_cnt == WW'(RD_WAIT - 1)) begin
                            tx         <= rd_mux[6:0];
                            o_spi_miso <= rd_mux[7];
                            state      <= DATA;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (is_write) rx <= {rx[5:0], mosi_s};
                            if (bit_cnt == 5'd15) begin
                                if (is_write) begin
                                    bus.o_data_out <= {rx[6:0], mosi_s};
                                    bus.o_cs       <= onehot(sel);
                                    bus.o_load_cmd <= 1'b1;
                                    state          <= LOAD;
                                end else begin
                                    o_spi_miso <= 1'b0;
                                    state      <= DONE;
                                end
                            end
                        end else if (sck_fall && !is_write &&
                                     bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
                            o_spi_miso <= tx[6];
                            tx         <= {tx[5:0], 1'b0};
                        end
                    end
                    LOAD: state <= DONE;
                    DONE: o_spi_miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
